// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with 2-entry skid buffer and sync flush
// Optional stall/transfer performance counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int CNT_WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic out_valid,
   input  logic out_ready,
`ifdef PIPE_STAGE_PERF_EN
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] xfer_cnt
`else
   output logic [WIDTH-1:0] out_data
`endif
);
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] main_data, skid_data, main_nx, skid_nx;
   logic acc, xfer;
   assign in_ready = (state != FULL) & ~flush;
   assign out_valid = state != EMPTY;
   assign out_data = main_data;
   assign acc = in_valid & in_ready;
   assign xfer = out_valid & out_ready;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
         main_data <= RESET_VAL;
         skid_data <= RESET_VAL;
      end else begin
         state <= state_nx;
         main_data <= main_nx;
         skid_data <= skid_nx;
      end
   end
   // flush never coincides with acc because in_ready is gated by flush
   always_comb begin
      state_nx = state;
      main_nx = main_data;
      skid_nx = skid_data;
      case (state)
         EMPTY: if (acc) begin
            main_nx = in_data;
            state_nx = BUSY;
         end
         BUSY: if (acc) begin
            main_nx = xfer ? in_data : main_data;
            skid_nx = xfer ? skid_data : in_data;
            state_nx = xfer ? BUSY : FULL;
         end else if (xfer) state_nx = EMPTY;
         FULL: if (xfer) begin
            main_nx = skid_data;
            state_nx = BUSY;
         end
         default: state_nx = EMPTY;
      endcase
      if (flush) state_nx = EMPTY;
   end
`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         xfer_cnt <= '0;
      end else begin
         if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
         if (xfer & ~&xfer_cnt) xfer_cnt <= xfer_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (counters checked under PIPE_STAGE_PERF_EN)
module tb_pipe_stage_reg;
   logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid;
   logic [31:0] in_data = '0, out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] stall_cnt, xfer_cnt;
`endif
   logic [31:0] exp_q[$];
   int n_chk = 0, n_fail = 0, n_xfer = 0, n_stall = 0;
   logic stall_prev = 0;
   logic [31:0] hold_d = '0;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_EN
      .out_data(out_data), .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`else
      .out_data(out_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // inputs change at negedge; acceptance is known once in_ready has settled
   task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = r; flush = f;
      #1;
      if (v && in_ready) exp_q.push_back(d);
   endtask

`ifdef PIPE_STAGE_PERF_EN
   task automatic chk_cnt(input string name);
      chk({name, "_stall_cnt"}, 64'(stall_cnt), 64'(n_stall > 65535 ? 65535 : n_stall));
      chk({name, "_xfer_cnt"}, 64'(xfer_cnt), 64'(n_xfer > 65535 ? 65535 : n_xfer));
   endtask
`endif

   // monitor: runs after the driver's settle point in the same half-cycle
   always @(negedge clk) begin
      #2;
      if (reset) stall_prev = 0;
      else begin
         if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(hold_d));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_xfer: got %0h expected none", out_data);
            end else chk("xfer_data", 64'(out_data), 64'(exp_q.pop_front()));
            n_xfer++;
         end
         if (out_valid && !out_ready) n_stall++;
         stall_prev = out_valid && !out_ready && !flush;
         hold_d = out_data;
         if (flush) exp_q.delete();
      end
   end

   initial begin
      int x0;
      int k;
      repeat (2) @(negedge clk);
      reset = 0;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_data", 64'(out_data), 64'd0);
      step(0, 0, 0, 0);
      chk("idle_out_valid", 64'(out_valid), 64'd0);

      x0 = n_xfer;
      for (int i = 1; i <= 100; i++) begin
         step(1, 32'(i), 1, 0);
         if (i > 1) begin
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_lat", 64'(out_data), 64'(i - 1));
         end
      end
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("stream_count", 64'(n_xfer - x0), 64'd100);
`ifdef PIPE_STAGE_PERF_EN
      chk_cnt("stream");
`endif

      step(1, 32'hA, 0, 0);
      step(1, 32'hB, 0, 0);
      step(0, 0, 0, 0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_data", 64'(out_data), 64'hA);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("bp_ready_back", 64'(in_ready), 64'd1);
      chk("bp_second", 64'(out_data), 64'hB);
      step(0, 0, 0, 0);
      chk("bp_empty", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      chk_cnt("bp");
`endif

      step(1, 32'hC, 0, 0);
      step(1, 32'hD, 0, 0);
      step(1, 32'hE, 0, 1);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      step(0, 0, 1, 0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      step(0, 0, 1, 0);
      chk("flush_still_empty", 64'(out_valid), 64'd0);

      step(1, 32'h5, 0, 0);
      x0 = n_xfer;
      step(0, 0, 1, 1);
      chk("fx_out_data", 64'(out_data), 64'h5);
      step(0, 0, 1, 0);
      chk("fx_empty", 64'(out_valid), 64'd0);
      chk("fx_once", 64'(n_xfer - x0), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
      chk_cnt("fx");
`endif

      step(1, 32'h11, 0, 0);
      step(1, 32'h22, 0, 0);
      step(0, 0, 0, 0);
      chk("rst_full_in_ready", 64'(in_ready), 64'd0);
      #2;
      reset = 1;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      chk("rst_async_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      n_xfer = 0;
      n_stall = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst_out_data", 64'(out_data), 64'd0);

      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 200) begin
         step(0, 0, 1, 0);
         k++;
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_empty", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      chk_cnt("rand");
      step(1, 32'h77, 0, 0);
      repeat (65540) step(0, 0, 0, 0);
      chk("sat_stall", 64'(stall_cnt), 64'hFFFF);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("sat_hold", 64'(stall_cnt), 64'hFFFF);
      chk_cnt("sat");
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
